// File: rtl/regfile_pkg.sv
// Shared defaults, constants and the write-port priority rule for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned ZERO_ADDR  = 0;

  typedef enum logic [1:0] {
    WSEL_NONE,
    WSEL_P1,
    WSEL_P2
  } wsel_e;

  // Port 2 always beats port 1 when both hit the same register.
  function automatic wsel_e wr_select(input logic hit1, input logic hit2);
    if (hit2) return WSEL_P2;
    if (hit1) return WSEL_P1;
    return WSEL_NONE;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: register mux, same-cycle write bypass, zero-register masking, optional output register.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned READ_REG = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [ADDR_W-1:0]                  addr_i,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] regs_i,
  input  logic [(1<<ADDR_W)-1:0]             pending_i,
  input  logic                               we1_i,
  input  logic [ADDR_W-1:0]                  wa1_i,
  input  logic [DATA_W-1:0]                  wd1_i,
  input  logic                               we2_i,
  input  logic [ADDR_W-1:0]                  wa2_i,
  input  logic [DATA_W-1:0]                  wd2_i,
  input  logic                               claim_i,
  input  logic [ADDR_W-1:0]                  claim_addr_i,
  output logic [DATA_W-1:0]                  data_o,
  output logic                               busy_o
);

  logic [DATA_W-1:0] data_c, data_q;
  logic              busy_c, busy_q;
  wsel_e             sel;

  always_comb begin
    sel    = wr_select(we1_i && (wa1_i == addr_i), we2_i && (wa2_i == addr_i));
    data_c = regs_i[addr_i];
    busy_c = pending_i[addr_i];
    if (BYPASS != 0) begin
      case (sel)
        WSEL_P2: data_c = wd2_i;
        WSEL_P1: data_c = wd1_i;
        default: ;
      endcase
      // A same-cycle claim re-arms the pending bit, so it keeps busy visible.
      if (sel != WSEL_NONE && !(claim_i && (claim_addr_i == addr_i))) busy_c = 1'b0;
    end
    if (ZERO_REG != 0 && addr_i == ADDR_W'(ZERO_ADDR)) begin
      data_c = '0;
      busy_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_c;
      busy_q <= busy_c;
    end
  end

  // Reset masks the combinational path too, so bypassed write data never leaks out during reset.
  always_comb begin
    data_o = '0;
    busy_o = 1'b0;
    if (rst_n) begin
      data_o = (READ_REG != 0) ? data_q : data_c;
      busy_o = (READ_REG != 0) ? busy_q : busy_c;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised 2-read/2-write register file with per-register pending (scoreboard) bits.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned READ_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              wr_en2,
  input  logic [ADDR_W-1:0] wr_addr2,
  input  logic [DATA_W-1:0] wr_data2,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              any_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]             pend_q, pend_d;
  logic                         we1, we2, claim;

  // Writes/claims to the hardwired zero register are dropped before they reach any logic.
  always_comb begin
    we1   = wr_en1   && !(ZERO_REG != 0 && wr_addr1   == ADDR_W'(ZERO_ADDR));
    we2   = wr_en2   && !(ZERO_REG != 0 && wr_addr2   == ADDR_W'(ZERO_ADDR));
    claim = claim_en && !(ZERO_REG != 0 && claim_addr == ADDR_W'(ZERO_ADDR));
  end

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      case (wr_select(we1 && (wr_addr1 == ADDR_W'(i)), we2 && (wr_addr2 == ADDR_W'(i))))
        WSEL_P2: begin
          regs_d[i] = wr_data2;
          pend_d[i] = 1'b0;
        end
        WSEL_P1: begin
          regs_d[i] = wr_data1;
          pend_d[i] = 1'b0;
        end
        default: ;
      endcase
      if (claim && (claim_addr == ADDR_W'(i))) pend_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  assign any_busy = |pend_q;

  regfile_rdport #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS),
    .READ_REG(READ_REG)
  ) u_rd1 (
    .clk         (clk),
    .rst_n       (reset),
    .addr_i      (rd_addr1),
    .regs_i      (regs_q),
    .pending_i   (pend_q),
    .we1_i       (we1),
    .wa1_i       (wr_addr1),
    .wd1_i       (wr_data1),
    .we2_i       (we2),
    .wa2_i       (wr_addr2),
    .wd2_i       (wr_data2),
    .claim_i     (claim),
    .claim_addr_i(claim_addr),
    .data_o      (rd_data1),
    .busy_o      (rd_busy1)
  );

  regfile_rdport #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS),
    .READ_REG(READ_REG)
  ) u_rd2 (
    .clk         (clk),
    .rst_n       (reset),
    .addr_i      (rd_addr2),
    .regs_i      (regs_q),
    .pending_i   (pend_q),
    .we1_i       (we1),
    .wa1_i       (wr_addr1),
    .wd1_i       (wr_data1),
    .we2_i       (we2),
    .wa2_i       (wr_addr2),
    .wd2_i       (wr_data2),
    .claim_i     (claim),
    .claim_addr_i(claim_addr),
    .data_o      (rd_data2),
    .busy_o      (rd_busy2)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two configurations of regfile_mp driven together and checked against an array model.
module tb_regfile_mp;

  typedef struct packed {
    logic [3:0]  ra1, ra2;
    logic        we1;
    logic [3:0]  wa1;
    logic [31:0] wd1;
    logic        we2;
    logic [3:0]  wa2;
    logic [31:0] wd2;
    logic        ce;
    logic [3:0]  ca;
  } stim_t;

  typedef struct packed {
    logic [31:0] d1, d2;
    logic        b1, b2, any;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  stim_t cur = '0;

  logic [31:0] a_d1, a_d2;
  logic        a_b1, a_b2, a_any;
  logic [15:0] b_d1, b_d2;
  logic        b_b1, b_b2, b_any;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Model state: index 0 = config A (8x32, zero reg, bypass, comb read); 1 = config B (16x16, registered read).
  logic [31:0] mem  [2][16];
  logic        pend [2][16];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1), .READ_REG(0)) u_dut_a (
    .clk(clk), .reset(reset),
    .rd_addr1(cur.ra1[2:0]), .rd_addr2(cur.ra2[2:0]),
    .rd_data1(a_d1), .rd_data2(a_d2), .rd_busy1(a_b1), .rd_busy2(a_b2),
    .wr_en1(cur.we1), .wr_addr1(cur.wa1[2:0]), .wr_data1(cur.wd1),
    .wr_en2(cur.we2), .wr_addr2(cur.wa2[2:0]), .wr_data2(cur.wd2),
    .claim_en(cur.ce), .claim_addr(cur.ca[2:0]), .any_busy(a_any)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0), .READ_REG(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .rd_addr1(cur.ra1), .rd_addr2(cur.ra2),
    .rd_data1(b_d1), .rd_data2(b_d2), .rd_busy1(b_b1), .rd_busy2(b_b2),
    .wr_en1(cur.we1), .wr_addr1(cur.wa1), .wr_data1(cur.wd1[15:0]),
    .wr_en2(cur.we2), .wr_addr2(cur.wa2), .wr_data2(cur.wd2[15:0]),
    .claim_en(cur.ce), .claim_addr(cur.ca), .any_busy(b_any)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic logic [3:0] amask(input int d, input logic [3:0] a);
    return (d == 0) ? {1'b0, a[2:0]} : a;
  endfunction

  function automatic logic [31:0] dmask(input int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic int depth(input int d);
    return (d == 0) ? 8 : 16;
  endfunction

  // Value a read port would present for this cycle's stimulus, before the edge commits it.
  function automatic void ref_read(input int d, input logic [3:0] a, input stim_t s,
                                   output logic [31:0] data, output logic busy);
    logic       zero, byp, h1, h2, hc;
    logic [3:0] x;
    zero = (d == 0);
    byp  = (d == 0);
    x    = amask(d, a);
    h1   = s.we1 && amask(d, s.wa1) == x && !(zero && x == 0);
    h2   = s.we2 && amask(d, s.wa2) == x && !(zero && x == 0);
    hc   = s.ce  && amask(d, s.ca)  == x && !(zero && x == 0);
    data = mem[d][x];
    busy = pend[d][x];
    if (byp) begin
      if (h2)      data = s.wd2 & dmask(d);
      else if (h1) data = s.wd1 & dmask(d);
      if ((h1 || h2) && !hc) busy = 1'b0;
    end
    if (zero && x == 0) begin
      data = '0;
      busy = 1'b0;
    end
  endfunction

  // Apply writes in priority order (port 2 last so it wins), then the claim.
  function automatic void ref_commit(input int d, input stim_t s);
    logic zero;
    zero = (d == 0);
    if (s.we1 && !(zero && amask(d, s.wa1) == 0)) begin
      mem[d][amask(d, s.wa1)]  = s.wd1 & dmask(d);
      pend[d][amask(d, s.wa1)] = 1'b0;
    end
    if (s.we2 && !(zero && amask(d, s.wa2) == 0)) begin
      mem[d][amask(d, s.wa2)]  = s.wd2 & dmask(d);
      pend[d][amask(d, s.wa2)] = 1'b0;
    end
    if (s.ce && !(zero && amask(d, s.ca) == 0)) pend[d][amask(d, s.ca)] = 1'b1;
  endfunction

  function automatic logic any_pend(input int d);
    logic r;
    r = 1'b0;
    for (int i = 0; i < depth(d); i++) r = r | pend[d][i];
    return r;
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) begin
        mem[d][i]  = '0;
        pend[d][i] = 1'b0;
      end
  endfunction

  function automatic stim_t mk(input logic [3:0] ra1, input logic [3:0] ra2,
                               input logic we1, input logic [3:0] wa1, input logic [31:0] wd1,
                               input logic we2, input logic [3:0] wa2, input logic [31:0] wd2,
                               input logic ce, input logic [3:0] ca);
    stim_t s;
    s.ra1 = ra1; s.ra2 = ra2;
    s.we1 = we1; s.wa1 = wa1; s.wd1 = wd1;
    s.we2 = we2; s.wa2 = wa2; s.wd2 = wd2;
    s.ce  = ce;  s.ca  = ca;
    return s;
  endfunction

  // Half the time addresses come from a narrow range to force port and claim collisions.
  function automatic logic [3:0] raddr();
    return ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
  endfunction

  function automatic stim_t rnd_stim();
    return mk(raddr(), raddr(),
              1'($urandom_range(0, 1)), raddr(), $urandom(),
              1'($urandom_range(0, 1)), raddr(), $urandom(),
              ($urandom_range(0, 3) == 0), raddr());
  endfunction

  task automatic drive(input stim_t s);
    exp_t ea, eb;
    @(negedge clk);
    cur = s;
    ref_read(0, s.ra1, s, ea.d1, ea.b1);
    ref_read(0, s.ra2, s, ea.d2, ea.b2);
    ea.any = any_pend(0);
    qa.push_back(ea);
    ref_read(1, s.ra1, s, eb.d1, eb.b1);
    ref_read(1, s.ra2, s, eb.d2, eb.b2);
    ref_commit(0, s);
    ref_commit(1, s);
    eb.any = any_pend(1);
    qb.push_back(eb);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_rd_data1"}, a_d1, 32'h0);
    check({tag, "_a_rd_data2"}, a_d2, 32'h0);
    check({tag, "_a_rd_busy1"}, 32'(a_b1), 32'h0);
    check({tag, "_a_rd_busy2"}, 32'(a_b2), 32'h0);
    check({tag, "_a_any_busy"}, 32'(a_any), 32'h0);
    check({tag, "_b_rd_data1"}, 32'(b_d1), 32'h0);
    check({tag, "_b_rd_data2"}, 32'(b_d2), 32'h0);
    check({tag, "_b_rd_busy1"}, 32'(b_b1), 32'h0);
    check({tag, "_b_rd_busy2"}, 32'(b_b2), 32'h0);
    check({tag, "_b_any_busy"}, 32'(b_any), 32'h0);
  endtask

  // Asserted mid-cycle while a bypassing write is still on the inputs.
  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("midrst");
    qa.delete();
    qb.delete();
    model_clear();
    @(negedge clk);
    cur   = '0;
    reset = 1'b1;
  endtask

  // Config A is combinational: sample late in the cycle, just before the edge.
  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (reset && qa.size() != 0) begin
        e = qa.pop_front();
        check("a_rd_data1", a_d1, e.d1);
        check("a_rd_data2", a_d2, e.d2);
        check("a_rd_busy1", 32'(a_b1), 32'(e.b1));
        check("a_rd_busy2", 32'(a_b2), 32'(e.b2));
        check("a_any_busy", 32'(a_any), 32'(e.any));
      end
    end
  end

  // Config B registers its reads: the value appears just after the edge that follows the address.
  initial begin : mon_b
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset && qb.size() != 0) begin
        e = qb.pop_front();
        check("b_rd_data1", 32'(b_d1), e.d1);
        check("b_rd_data2", 32'(b_d2), e.d2);
        check("b_rd_busy1", 32'(b_b1), 32'(e.b1));
        check("b_rd_busy2", 32'(b_b2), 32'(e.b2));
        check("b_any_busy", 32'(b_any), 32'(e.any));
      end
    end
  end

  initial begin : stim
    model_clear();
    cur = rnd_stim();
    cur.we1 = 1'b1; cur.we2 = 1'b1; cur.ce = 1'b1;
    #1 reset = 1'b0;
    #2 check_all_zero("reset");
    repeat (2) @(negedge clk);
    cur   = '0;
    reset = 1'b1;

    for (int i = 0; i < 16; i += 2) drive(mk(4'(i), 4'(i + 1), 0, 0, 0, 0, 0, 0, 0, 0));

    drive(mk(0, 0, 1, 1, 32'h0000_00A1, 0, 0, 0, 0, 0));
    drive(mk(1, 0, 1, 0, 32'h0000_00FF, 0, 0, 0, 0, 0));
    drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(3, 3, 1, 3, 32'h11, 1, 3, 32'h22, 0, 0));
    drive(mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 5));
    drive(mk(5, 5, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(5, 4, 1, 5, 32'h55, 0, 0, 0, 0, 0));
    drive(mk(5, 5, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(5, 5, 0, 0, 0, 1, 5, 32'h55, 1, 5));
    drive(mk(5, 5, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    drive(mk(0, 15, 1, 15, 32'h0000_BEEF, 0, 0, 0, 0, 0));
    drive(mk(15, 14, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    pulse_reset();
    drive(mk(1, 15, 1, 2, 32'h1234_5678, 0, 0, 0, 0, 0));
    drive(mk(2, 15, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 400; i++) begin
      drive(rnd_stim());
      if (i == 200) pulse_reset();
    end

    @(negedge clk);
    cur = '0;
    repeat (3) @(negedge clk);
    check("drain_qa", 32'(qa.size()), 32'h0);
    check("drain_qb", 32'(qb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
